// File: rtl/dawg_req_arbiter_pkg.sv
// Shared cache types for the DAWG partitioned cache: CPU request/result structs,
// arbiter state encoding and domain helpers. Time-slice mode: DAWG_ARB_TIMESLICE_EN.
package dawg_req_arbiter_pkg;

    localparam int NUM_DOMAINS = 4;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic              valid;
        logic              rw;
        logic              flush;
        logic [1:0]        domain_id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cpu_req_type;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } cpu_result_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    // OR-encoding is exact for a one-hot input and yields 0 for an all-zero input.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_DOMAINS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (oh[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dawg_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid port strictly after last_winner_i,
// wrapping modulo N, returned one-hot with a found flag.
module dawg_rr_pick
    import dawg_req_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] valid_i,
    input  logic [1:0]   last_winner_i,
    output logic [N-1:0] winner_o,
    output logic         found_o
);

    // k is the rotation distance from the last winner; the lowest k that hits a valid port wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found_o && valid_i[i] && (((int'(last_winner_i) + k) % N) == i)) begin
                    winner_o[i] = 1'b1;
                    found_o     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dawg_req_arbiter.sv
// Arbitrates NUM_REQ domain ports onto the single cache CPU port, stamping domain_id by port.
// Defining DAWG_ARB_TIMESLICE_EN replaces round robin with fixed per-domain slot starts.
module dawg_req_arbiter
    import dawg_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SLOT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  cpu_req_type          req_i [NUM_REQ],
    output cpu_result_type       res_o [NUM_REQ],
    output cpu_req_type          cache_req_o,
    input  cpu_result_type       cache_res_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 overrun_o
);

    if (NUM_REQ < 2 || NUM_REQ > NUM_DOMAINS || SLOT_CYCLES < 2) begin : g_bad_params
        $error("dawg_req_arbiter: NUM_REQ must be 2..4 and SLOT_CYCLES at least 2");
    end

    arb_state_t           stateQ;
    cpu_req_type          cacheReqQ;
    cpu_result_type       resQ [NUM_REQ];
    logic [NUM_REQ-1:0]   grantQ;
    logic [1:0]           lastWinnerQ;

    logic [NUM_REQ-1:0]   validVec;
    logic [NUM_REQ-1:0]   eligibleD;
    logic [NUM_REQ-1:0]   winnerD;
    logic                 foundD;
    logic [1:0]           winIdxD;
    cpu_req_type          pickedReqD;

    always_comb begin
        validVec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            validVec[i] = req_i[i].valid;
        end
    end

`ifdef DAWG_ARB_TIMESLICE_EN
    localparam int SLOT_W = $clog2(SLOT_CYCLES);

    logic [SLOT_W-1:0] slotCntQ;
    logic [1:0]        slotOwnerQ;
    logic              overrunQ;

    // Slots rotate regardless of demand so issue timing never depends on other domains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotCntQ   <= '0;
            slotOwnerQ <= '0;
            overrunQ   <= 1'b0;
        end else begin
            if (slotCntQ == SLOT_W'(SLOT_CYCLES - 1)) begin
                slotCntQ   <= '0;
                slotOwnerQ <= (slotOwnerQ == 2'(NUM_REQ - 1)) ? 2'd0 : slotOwnerQ + 2'd1;
            end else begin
                slotCntQ <= slotCntQ + 1'b1;
            end
            if (slotCntQ == '0 && stateQ != IDLE) begin
                overrunQ <= 1'b1;
            end
        end
    end

    always_comb begin
        eligibleD = '0;
        if (slotCntQ == '0) begin
            eligibleD[slotOwnerQ] = validVec[slotOwnerQ];
        end
    end

    assign overrun_o = overrunQ;
`else
    assign eligibleD = validVec;
    assign overrun_o = 1'b0;
`endif

    dawg_rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .valid_i       (eligibleD),
        .last_winner_i (lastWinnerQ),
        .winner_o      (winnerD),
        .found_o       (foundD)
    );

    assign winIdxD = onehot_to_idx(NUM_DOMAINS'(winnerD));

    // The requester's own domain_id is never trusted; the port number is the domain.
    always_comb begin
        pickedReqD           = req_i[winIdxD];
        pickedReqD.valid     = 1'b1;
        pickedReqD.domain_id = winIdxD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= IDLE;
            cacheReqQ   <= '0;
            grantQ      <= '0;
            lastWinnerQ <= 2'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                resQ[i] <= '0;
            end
        end else begin
            case (stateQ)
                IDLE: begin
                    if (foundD) begin
                        cacheReqQ   <= pickedReqD;
                        grantQ      <= winnerD;
                        lastWinnerQ <= winIdxD;
                        stateQ      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cache_res_i.ready) begin
                        resQ[lastWinnerQ].ready <= 1'b1;
                        resQ[lastWinnerQ].data  <= cache_res_i.data;
                        cacheReqQ.valid         <= 1'b0;
                        stateQ                  <= RESP;
                    end
                end
                RESP: begin
                    resQ[lastWinnerQ].ready <= 1'b0;
                    grantQ                  <= '0;
                    stateQ                  <= IDLE;
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign cache_req_o = cacheReqQ;
    assign grant_o     = grantQ;
    assign res_o       = resQ;

endmodule
